// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises the raw bus, deframes 11-bit frames and
// turns the scan-code byte stream (E0/F0 prefixes) into make-code strobes.
module ps2_key_decoder #(
    parameter int TIMEOUT = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_in,
    output logic       key_en,
    output logic       key_ext,
    output logic       frame_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // A frame is good when the stop bit is high and data plus parity hold an odd number of ones.
    function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
        return stop & ((^data) ^ par);
    endfunction

    logic       ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_s3_q;
    logic       ps2_data_s1_q, ps2_data_s2_q;
    logic       fall_s, data_s, timeout_s;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_q, parity_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [7:0] key_in_q, key_in_d;
    logic       key_ext_q, key_ext_d;
    logic       key_en_q, key_en_d;
    logic       frame_err_q, frame_err_d;

    assign fall_s    = ps2_clk_s3_q & ~ps2_clk_s2_q;
    assign data_s    = ps2_data_s2_q;
    assign timeout_s = (state_q != ST_IDLE) && !fall_s && (tmo_q == TMO_LIMIT);

    // Bus synchronisers; reset to the idle-high bus level so no edge is seen on release.
    always_ff @(posedge clock) begin
        if (reset) begin
            ps2_clk_s1_q  <= 1'b1;
            ps2_clk_s2_q  <= 1'b1;
            ps2_clk_s3_q  <= 1'b1;
            ps2_data_s1_q <= 1'b1;
            ps2_data_s2_q <= 1'b1;
        end else begin
            ps2_clk_s1_q  <= ps2_clk;
            ps2_clk_s2_q  <= ps2_clk_s1_q;
            ps2_clk_s3_q  <= ps2_clk_s2_q;
            ps2_data_s1_q <= ps2_data;
            ps2_data_s2_q <= ps2_data_s1_q;
        end
    end

    // Inter-edge watchdog: restarts on each falling edge, idle while no frame is open.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == ST_IDLE || fall_s) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_LIMIT) begin
            tmo_d = tmo_q + CW'(1);
        end else begin
            tmo_d = tmo_q;
        end
    end

    // Deframing FSM and scan-code interpretation.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        key_in_d    = key_in_q;
        key_ext_d   = key_ext_q;
        key_en_d    = 1'b0;
        frame_err_d = 1'b0;
        if (timeout_s) begin
            state_d     = ST_IDLE;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
            frame_err_d = 1'b1;
        end else if (fall_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    parity_d = data_s;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!frame_ok(shift_q, parity_q, data_s)) begin
                        frame_err_d = 1'b1;
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end else if (shift_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else if (brk_q) begin
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end else begin
                        key_in_d  = shift_q;
                        key_ext_d = ext_q;
                        key_en_d  = 1'b1;
                        ext_d     = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            key_in_q    <= 8'h00;
            key_ext_q   <= 1'b0;
            key_en_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            key_in_q    <= key_in_d;
            key_ext_q   <= key_ext_d;
            key_en_q    <= key_en_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign key_in    = key_in_q;
    assign key_en    = key_en_q;
    assign key_ext   = key_ext_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter: TIMEOUT, default 50000; max clock cycles allowed between consecutive PS/2 falling edges within a frame.
REQ-002 clock  input  1  system clock; all logic SHALL be clocked on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ps2_clk  input  1  raw PS/2 clock from keyboard, asynchronous.
REQ-005 ps2_data  input  1  raw PS/2 data from keyboard, asynchronous.
REQ-006 key_in  output  8  last accepted make scan code, held until the next accepted make code.
REQ-007 key_en  output  1  one-cycle strobe; key_in and key_ext are valid in the same cycle.
REQ-008 key_ext  output  1  1 when the accepted make code was preceded by the E0 prefix.
REQ-009 frame_err  output  1  one-cycle strobe on a parity, stop or timeout error.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a third flop on clock SHALL form the falling-edge detect (previous=1, current=0).
REQ-011 Frame format: start bit 0, 8 data bits LSB first, odd parity bit, stop bit 1; bits are sampled from synchronized ps2_data on a detected falling edge.
REQ-012 FSM states: IDLE, DATA, PARITY, STOP.
REQ-013 IDLE: on a falling edge with data=0, go to DATA with bit count 0; on a falling edge with data=1, stay in IDLE with no error.
REQ-014 DATA: shift in one bit per falling edge; after the 8th bit, go to PARITY.
REQ-015 PARITY: capture the parity bit and go to STOP.
REQ-016 STOP: on the falling edge, if stop=1 and (XOR of 8 data bits XOR parity)=1, accept the byte; otherwise pulse frame_err. Either way return to IDLE.
REQ-017 Timeout counter: cleared on every falling edge and in IDLE; counts in DATA, PARITY and STOP.
REQ-018 If the timeout counter reaches TIMEOUT, the FSM SHALL return to IDLE, pulse frame_err for one cycle and clear the ext and brk flags.
REQ-019 Accepted byte 8'hE0: set the ext flag; no key_en.
REQ-020 Accepted byte 8'hF0: set the brk flag; no key_en.
REQ-021 Any other accepted byte with brk=1 (release event): clear ext and brk; no key_en; key_in is unchanged.
REQ-022 Any other accepted byte with brk=0 (make event): load key_in with the byte and key_ext with ext, pulse key_en, and clear ext.
REQ-023 Latency: key_en SHALL assert exactly 1 clock cycle after the cycle in which the stop-bit falling edge is detected. frame_err SHALL use the same timing.
REQ-024 A frame_err SHALL clear the ext and brk flags; the erroneous byte SHALL have no effect on key_in or key_ext.
REQ-025 key_en and frame_err SHALL never assert in the same cycle, and neither SHALL be high for more than 1 cycle per frame.
REQ-026 Typematic repeat (the same make code received again) SHALL produce a fresh key_en each time.

Reset
REQ-027 While reset=1, the FSM SHALL be in IDLE, and the bit count, shift register, timeout counter, ext and brk SHALL all be 0.
REQ-028 While reset=1, the outputs SHALL be key_in=8'h00, key_en=0, key_ext=0, frame_err=0, and all synchronizer flops SHALL be set to 1 (bus idle).
REQ-029 Reset asserted mid-frame SHALL abandon the frame; no key_en or frame_err SHALL result from the partial frame.

Verification
REQ-030 Frame 8'h1C with correct parity -> key_in=8'h1C, key_ext=0, one key_en pulse, frame_err stays 0.
REQ-031 Frames E0,75 -> a single key_en pulse with key_in=8'h75 and key_ext=1; no pulse for the E0 frame.
REQ-032 Frames E0,F0,75 (release) -> no key_en, key_in keeps its previous value. A following 8'h6B frame -> key_in=8'h6B, key_ext=0.
REQ-033 Frame 8'h72 with the parity bit inverted -> frame_err pulses once, no key_en. A following E0,72 sequence -> key_ext=1.
REQ-034 Frame stopped after 4 data bits, with ps2_clk held high for TIMEOUT+10 cycles -> frame_err pulses once and the FSM returns to IDLE. A following good 8'h74 frame -> key_en with key_in=8'h74.
REQ-035 reset pulsed after the 5th bit of a frame -> no key_en and no frame_err from that frame. The next good 8'h1C frame decodes correctly.
